// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared constants and FSM encoding for stochastic-computing blocks
package sc_pkg;

  localparam int LFSR_WIDTH = 10;
  localparam int SC_WINDOW  = 1023;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } stb_state_t;

endpackage

// File: rtl/sc_window_ctr.sv
// rtl/sc_window_ctr.sv - valid-bit counter flagging the WINDOW-th accepted bit
module sc_window_ctr
  import sc_pkg::*;
#(
  parameter int WIDTH  = LFSR_WIDTH,
  parameter int WINDOW = SC_WINDOW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [WIDTH-1:0] TC = WIDTH'(WINDOW - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  // Asserted in the same cycle the final bit is accepted, not after it.
  assign last = en && (count == TC);

endmodule

// File: rtl/stoch_to_bin.sv
// rtl/stoch_to_bin.sv - stochastic bitstream to binary converter over a fixed window
// Optional STB_BIPOLAR_EN: result = 2*ones - WINDOW (two's complement) instead of ones count.
module stoch_to_bin
  import sc_pkg::*;
#(
  parameter int WIDTH  = LFSR_WIDTH,
  parameter int WINDOW = SC_WINDOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  input  logic             result_ready
);

  stb_state_t       state;
  stb_state_t       state_next;
  logic [WIDTH-1:0] ones_cnt;
  logic [WIDTH-1:0] ones_next;
  logic             accept;
  logic             ctr_clr;
  logic             last_bit;

  assign accept    = (state == ACCUM) && bit_valid && !clr;
  assign ctr_clr   = clr || (state != ACCUM);
  assign ones_next = ones_cnt + {{(WIDTH-1){1'b0}}, bit_in};

  sc_window_ctr #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW)
  ) u_window_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .en    (accept),
    .last  (last_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)        state_next = ACCUM;
      ACCUM:   if (last_bit)     state_next = DONE;
      DONE:    if (result_ready) state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
    if (clr) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt <= '0;
    end else if (ctr_clr) begin
      ones_cnt <= '0;
    end else if (bit_valid) begin
      ones_cnt <= ones_next;
    end
  end

`ifdef STB_BIPOLAR_EN
  localparam logic [WIDTH:0] WIN_EXT = (WIDTH + 1)'(WINDOW);
`endif

  // Result is captured from ones_next so the final bit is included without an extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (last_bit) begin
`ifdef STB_BIPOLAR_EN
      result <= {ones_next, 1'b0} - WIN_EXT;
`else
      result <= {1'b0, ones_next};
`endif
    end
  end

  assign busy         = (state == ACCUM);
  assign result_valid = (state == DONE);

endmodule

// File: tb/tb_stoch_to_bin.sv
// tb/tb_stoch_to_bin.sv - self-checking bench for stoch_to_bin (table-driven windows plus corner sequences)
module tb_stoch_to_bin;
  import sc_pkg::*;

  localparam int W   = LFSR_WIDTH;
  localparam int WIN = SC_WINDOW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clr = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         result_ready = 1'b0;
  logic         busy;
  logic         result_valid;
  logic [W:0]   result;

  stoch_to_bin #(.WIDTH(W), .WINDOW(WIN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clr          (clr),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  typedef enum int {M_ONES, M_ZEROS, M_LFSR, M_ALT} mode_t;

  typedef struct {
    mode_t      mode;
    int         hold;
    logic [W:0] exp_uni;
    logic [W:0] exp_bip;
  } vec_t;

  vec_t       vecs[4];
  logic [W:0] sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [W-1:0] lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [W:0] pick(input logic [W:0] uni, input logic [W:0] bip);
`ifdef STB_BIPOLAR_EN
    return bip;
`else
    return uni;
`endif
  endfunction

  task automatic run_window(input mode_t mode, input int hold, input logic [W:0] exp, input string tag);
    int n = 0;
    int cyc = 0;
    int early = 0;
    int unstable = 0;
    logic [W:0] held;
    logic [W:0] exp_pop;
    @(negedge clk);
    start = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    sb_q.push_back(exp);
    lfsr = 10'b1100000000;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s busy after start", tag), 32'(busy), 32'd1);
    while (n < WIN) begin
      case (mode)
        M_ONES:  begin bit_valid = 1'b1; bit_in = 1'b1; end
        M_ZEROS: begin bit_valid = 1'b1; bit_in = 1'b0; end
        M_LFSR: begin
          bit_valid = 1'b1;
          bit_in = (lfsr < 10'd512);
          lfsr = {lfsr[W-2:0], lfsr[9] ^ lfsr[6]};
        end
        default: begin
          bit_valid = (cyc[0] == 1'b0);
          bit_in = bit_valid ? ~n[0] : 1'b1;
        end
      endcase
      start = ((cyc % 7) == 3);
      if (bit_valid) n++;
      cyc++;
      @(negedge clk);
      if (n < WIN && (result_valid || !busy)) early++;
    end
    start = 1'b0;
    check($sformatf("%s early done", tag), 32'(early), 32'd0);
    check($sformatf("%s valid one cycle after last bit", tag), 32'(result_valid), 32'd1);
    check($sformatf("%s busy low in done", tag), 32'(busy), 32'd0);
    exp_pop = sb_q.pop_front();
    check($sformatf("%s result", tag), 32'(result), 32'(exp_pop));
    held = result;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    start = 1'b1;
    result_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!result_valid || result !== held) unstable++;
    end
    if (hold > 0) check($sformatf("%s held while not ready", tag), 32'(unstable), 32'd0);
    start = 1'b0;
    bit_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check($sformatf("%s idle after handshake", tag), 32'({busy, result_valid}), 32'd0);
    check($sformatf("%s result retained", tag), 32'(result), 32'(held));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W:0] prev;
    int bad;

    vecs[0] = '{M_ONES,  0,  11'd1023, 11'h3FF};
    vecs[1] = '{M_ZEROS, 0,  11'd0,    11'h401};
    vecs[2] = '{M_LFSR,  0,  11'd511,  11'h7FF};
    vecs[3] = '{M_ALT,   20, 11'd512,  11'h001};

    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset result_valid", 32'(result_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      run_window(vecs[v].mode, vecs[v].hold, pick(vecs[v].exp_uni, vecs[v].exp_bip),
                 $sformatf("vec%0d", v));
    end

    // start and clr together in IDLE must not leave IDLE
    @(negedge clk);
    start = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr = 1'b0;
    check("start+clr stays idle", 32'(busy), 32'd0);

    // abort after 300 bits
    prev = result;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    repeat (300) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr busy", 32'(busy), 32'd0);
    check("clr result_valid", 32'(result_valid), 32'd0);
    check("clr result retained", 32'(result), 32'(prev));
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || result_valid) bad++;
    end
    bit_valid = 1'b0;
    check("clr stays idle", 32'(bad), 32'd0);
    run_window(M_ONES, 0, pick(11'd1023, 11'h3FF), "after clr");

    // asynchronous reset mid-window
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    repeat (100) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst result_valid", 32'(result_valid), 32'd0);
    check("async rst result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || result_valid) bad++;
    end
    bit_valid = 1'b0;
    check("idle after reset until start", 32'(bad), 32'd0);
    run_window(M_ALT, 0, pick(11'd512, 11'h001), "after reset");

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
